// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer: Moore FSM with a per-phase reload
// down-counter, latched side/pedestrian requests and registered light outputs.
module traffic_phase_ctrl #(
  parameter int CW   = 11,
  parameter int T_MG = 1800,
  parameter int T_Y  = 300,
  parameter int T_AR = 100,
  parameter int T_SG = 1200
) (
  input  logic          tclk,
  input  logic          rst_n,
  input  logic          sensor_side,
  input  logic          ped_req,
  output logic [2:0]    main_lights,
  output logic [2:0]    side_lights,
  output logic          walk,
  output logic [2:0]    phase,
  output logic [CW-1:0] count,
  output logic          tmo
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } phase_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  phase_e        phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;
  logic          side_q, side_d;
  logic          ped_q, ped_d;
  logic          walk_q, walk_d;
  logic [2:0]    main_q, main_d;
  logic [2:0]    sidel_q, sidel_d;
  logic          tmo_w, req_w, enter_w, enter_sg_w;

  function automatic logic [CW-1:0] load_val(input phase_e p);
    case (p)
      MG:      load_val = CW'(T_MG - 1);
      MY, SY:  load_val = CW'(T_Y - 1);
      SG:      load_val = CW'(T_SG - 1);
      default: load_val = CW'(T_AR - 1);
    endcase
  endfunction

  assign tmo_w = (count_q == '0);
  assign req_w = side_q | ped_q | sensor_side | ped_req;

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      MG:      if (tmo_w && req_w) phase_d = MY;
      MY:      if (tmo_w) phase_d = AR1;
      AR1:     if (tmo_w) phase_d = SG;
      SG:      if (tmo_w) phase_d = SY;
      SY:      if (tmo_w) phase_d = AR2;
      AR2:     if (tmo_w) phase_d = MG;
      default: phase_d = AR2;  // corrupted encoding recovers through all-red
    endcase

    enter_w    = (phase_d != phase_q);
    enter_sg_w = enter_w && (phase_d == SG);
    count_d    = enter_w ? load_val(phase_d)
                         : (tmo_w ? '0 : count_q - CW'(1));

    // Clear wins over set: a request seen on the SG entry edge is served now.
    side_d = (side_q | sensor_side) & ~enter_sg_w;
    ped_d  = (ped_q  | ped_req)     & ~enter_sg_w;

    if (enter_sg_w)          walk_d = ped_q | ped_req;
    else if (phase_d == SG)  walk_d = walk_q;
    else                     walk_d = 1'b0;

    main_d  = L_RED;
    sidel_d = L_RED;
    case (phase_d)
      MG:      main_d  = L_GRN;
      MY:      main_d  = L_YEL;
      SG:      sidel_d = L_GRN;
      SY:      sidel_d = L_YEL;
      default: ;
    endcase
  end

  always_ff @(posedge tclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= MG;
      count_q <= CW'(T_MG - 1);
      side_q  <= 1'b0;
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
      main_q  <= L_GRN;
      sidel_q <= L_RED;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      side_q  <= side_d;
      ped_q   <= ped_d;
      walk_q  <= walk_d;
      main_q  <= main_d;
      sidel_q <= sidel_d;
    end
  end

  assign main_lights = main_q;
  assign side_lights = sidel_q;
  assign walk        = walk_q;
  assign phase       = phase_q;
  assign count       = count_q;
  assign tmo         = tmo_w;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: one default-parameter instance for the
// long idle run, one short-timing instance for the phase sequence scenarios.
module tb_traffic_phase_ctrl;

  logic tclk = 1'b0;
  always #5 tclk = ~tclk;

  logic rst_n, sensor_side, ped_req;

  logic [2:0]  b_main, b_side, b_phase;
  logic        b_walk, b_tmo;
  logic [10:0] b_count;
  logic [2:0]  s_main, s_side, s_phase;
  logic        s_walk, s_tmo;
  logic [10:0] s_count;

  traffic_phase_ctrl u_big (
    .tclk(tclk), .rst_n(rst_n), .sensor_side(sensor_side), .ped_req(ped_req),
    .main_lights(b_main), .side_lights(b_side), .walk(b_walk),
    .phase(b_phase), .count(b_count), .tmo(b_tmo)
  );

  traffic_phase_ctrl #(.CW(11), .T_MG(8), .T_Y(3), .T_AR(2), .T_SG(5)) u_small (
    .tclk(tclk), .rst_n(rst_n), .sensor_side(sensor_side), .ped_req(ped_req),
    .main_lights(s_main), .side_lights(s_side), .walk(s_walk),
    .phase(s_phase), .count(s_count), .tmo(s_tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge tclk);
    #1;
  endtask

  task automatic do_reset();
    sensor_side = 1'b0;
    ped_req     = 1'b0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Expected state at sample i (i edges after reset release) for the short
  // timings; ncyc full service cycles are expected before MG holds for good.
  function automatic void exp_state(input int i, input int ncyc,
                                    output logic [2:0] ph, output int cnt);
    int lens[6] = '{8, 3, 2, 5, 3, 2};
    int cyc = 0;
    while (cyc < ncyc && i >= 23) begin
      i -= 23;
      cyc++;
    end
    if (cyc == ncyc) begin
      ph  = 3'd0;
      cnt = (i < 7) ? 7 - i : 0;
      return;
    end
    for (int p = 0; p < 6; p++) begin
      if (i < lens[p]) begin
        ph  = 3'(p);
        cnt = lens[p] - 1 - i;
        return;
      end
      i -= lens[p];
    end
    ph  = 3'd0;
    cnt = 0;
  endfunction

  function automatic logic [2:0] exp_main(input logic [2:0] ph);
    case (ph)
      3'd0:    exp_main = 3'b001;
      3'd1:    exp_main = 3'b010;
      default: exp_main = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input logic [2:0] ph);
    case (ph)
      3'd3:    exp_side = 3'b001;
      3'd4:    exp_side = 3'b010;
      default: exp_side = 3'b100;
    endcase
  endfunction

  // Runs nsamp samples on the short instance; sens_a/sens_b/ped_e are the edge
  // numbers on which a one-cycle pulse is applied (0 = none).
  task automatic run_small(input string tag, input int ncyc, input int sens_a,
                           input int sens_b, input int ped_e, input int nsamp);
    logic [2:0] ph;
    int cnt;
    for (int i = 0; i < nsamp; i++) begin
      exp_state(i, ncyc, ph, cnt);
      check({tag, ".phase"}, s_phase, ph);
      check({tag, ".count"}, s_count, cnt);
      check({tag, ".tmo"},   s_tmo,   (cnt == 0));
      check({tag, ".main"},  s_main,  exp_main(ph));
      check({tag, ".side"},  s_side,  exp_side(ph));
      check({tag, ".walk"},  s_walk,  (ped_e > 0) && (ph == 3'd3));
      sensor_side = (i + 1 == sens_a) || (i + 1 == sens_b);
      ped_req     = (i + 1 == ped_e);
      step();
    end
    sensor_side = 1'b0;
    ped_req     = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    sensor_side = 1'b0;
    ped_req     = 1'b0;

    // 1: default timings, idle main green
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      check("idle.phase", b_phase, 0);
      check("idle.count", b_count, (i < 1799) ? 1799 - i : 0);
      check("idle.tmo",   b_tmo,   (i >= 1799));
      check("idle.main",  b_main,  3'b001);
      check("idle.side",  b_side,  3'b100);
      step();
    end

    // 2: single sensor pulse, one full service cycle
    do_reset();
    run_small("seq", 1, 2, 0, 0, 35);

    // 3: request arriving while MG already expired
    do_reset();
    repeat (20) step();
    check("late.count0", s_count, 0);
    check("late.phase0", s_phase, 0);
    sensor_side = 1'b1;
    step();
    sensor_side = 1'b0;
    check("late.phase", s_phase, 1);
    check("late.count", s_count, 2);
    check("late.main",  s_main,  3'b010);

    // 4: pedestrian pulse gives walk for the SG only, then no repeat
    do_reset();
    run_small("ped", 1, 0, 0, 1, 35);

    // 5: sensor pulse during SY forces a second cycle after full MG
    do_reset();
    run_small("resv", 2, 2, 19, 0, 58);

    // 6: async reset mid-SG with a pending request
    do_reset();
    run_small("pre", 1, 2, 0, 0, 15);
    check("mid.phase", s_phase, 3);
    check("mid.count", s_count, 2);
    sensor_side = 1'b1;
    step();
    sensor_side = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.phase", s_phase, 0);
    check("arst.main",  s_main,  3'b001);
    check("arst.side",  s_side,  3'b100);
    check("arst.walk",  s_walk,  0);
    check("arst.count", s_count, 7);
    check("arst.tmo",   s_tmo,   0);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("post.phase", s_phase, 0);
      check("post.count", s_count, (i < 7) ? 7 - i : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
